// File: rtl/instr_fetch_loader.sv
// Instruction source for a single-cycle core: the host loads a program over a
// valid/ready port, then the block streams it out one word per cycle, honouring redirect and stall.
module instr_fetch_loader #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              run_start,
  input  logic              pcsrc,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  state_t            r_state;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  // One extra bit so a full program can run off the end without wrapping to 0
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_fetch_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] r_pc;
  logic              r_load_done;
  logic              r_halted;
  logic              r_error;

  logic              w_xfer;
  logic              w_wr_full;
  logic              w_load_end;
  logic              w_in_range;
  logic [31:0]       w_rd_data;

  assign w_xfer     = (r_state == S_LOAD) && load_valid;
  assign w_wr_full  = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_load_end = w_xfer && (load_last || w_wr_full);
  assign w_in_range = (r_fetch_pc < r_count);
  assign w_rd_data  = r_mem[r_fetch_pc[ADDR_W-1:0]];

  // Program storage survives reset; r_count gates every read instead
  always_ff @(posedge clk) begin
    if (w_xfer) r_mem[r_wr_ptr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fetch_pc    <= '0;
      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_pc          <= '0;
      r_load_done   <= 1'b0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (load_start) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
            r_error  <= 1'b0;
            r_halted <= 1'b0;
          end else if (run_start) begin
            if (r_count != '0) begin
              r_state    <= S_RUN;
              r_fetch_pc <= '0;
              r_halted   <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_load_end) begin
              r_count     <= {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
              r_load_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (pcsrc) begin
              r_fetch_pc    <= {1'b0, branch_target};
              r_instr       <= NOP_WORD;
              r_instr_valid <= 1'b0;
            end else if (w_in_range) begin
              r_instr       <= w_rd_data;
              r_pc          <= r_fetch_pc[ADDR_W-1:0];
              r_instr_valid <= 1'b1;
              r_fetch_pc    <= r_fetch_pc + (ADDR_W + 1)'(1);
            end else begin
              r_instr       <= NOP_WORD;
              r_instr_valid <= 1'b0;
              r_halted      <= 1'b1;
              r_state       <= S_HALT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_ready  = (r_state == S_LOAD);
  assign load_done   = r_load_done;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign error       = r_error;

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Directed bench for instr_fetch_loader: load, run, branch, stall, reset/error, full memory.
module tb_instr_fetch_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start, load_valid, load_last, load_ready, load_done;
  logic [31:0] load_data;
  logic        run_start, pcsrc, stall;
  logic [5:0]  branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        halted, error;

  int total = 0;
  int bad   = 0;

  instr_fetch_loader #(.DEPTH(64), .ADDR_W(6), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .run_start(run_start), .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] ei, input logic [5:0] ep);
    chk({tag, ".instr"}, instr, ei);
    chk({tag, ".pc"}, {26'd0, pc}, {26'd0, ep});
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic chk_bubble(input string tag, input logic exp_halt);
    chk({tag, ".instr"}, instr, 32'h0);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, exp_halt});
  endtask

  task automatic start_run();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = 32'h44;
    reset = 1'b0; load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
    run_start = 0; pcsrc = 0; stall = 0; branch_target = 0;

    // Reset state
    step(); step();
    chk("rst.instr", instr, 32'h0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.pc", {26'd0, pc}, 32'd0);
    chk("rst.ready", {31'd0, load_ready}, 32'd0);
    chk("rst.done", {31'd0, load_done}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.error", {31'd0, error}, 32'd0);
    reset = 1'b1;
    step();

    // Load 4 words, load_valid on every other cycle
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load.ready", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b0;
      step();
      chk("load.gap_done", {31'd0, load_done}, 32'd0);
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
      step();
      chk("load.done", {31'd0, load_done}, {31'd0, i == 3});
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("load.ready_off", {31'd0, load_ready}, 32'd0);
    step();
    chk("load.done_pulse", {31'd0, load_done}, 32'd0);

    // Straight run
    start_run();
    chk("run.e0_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_fetch("run", prog[i], 6'(i));
    end
    step();
    chk_bubble("run.end", 1'b1);

    // Branch back, then branch out of range
    start_run();
    chk("br.halt_clr", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("br.pre", prog[i], 6'(i));
    end
    pcsrc = 1'b1; branch_target = 6'd1;
    step();
    pcsrc = 1'b0;
    chk_bubble("br.bubble", 1'b0);
    step(); chk_fetch("br.t1", 32'h22, 6'd1);
    step(); chk_fetch("br.t2", 32'h33, 6'd2);
    pcsrc = 1'b1; branch_target = 6'd9;
    step();
    pcsrc = 1'b0;
    chk_bubble("br.oor_bubble", 1'b0);
    step();
    chk_bubble("br.oor_halt", 1'b1);

    // Stall for 3 cycles with a pcsrc pulse in the middle
    start_run();
    step(); chk_fetch("st.w0", 32'h11, 6'd0);
    step(); chk_fetch("st.w1", 32'h22, 6'd1);
    stall = 1'b1;
    step(); chk_fetch("st.hold1", 32'h22, 6'd1);
    pcsrc = 1'b1; branch_target = 6'd3;
    step(); chk_fetch("st.hold2", 32'h22, 6'd1);
    pcsrc = 1'b0;
    step(); chk_fetch("st.hold3", 32'h22, 6'd1);
    stall = 1'b0;
    step(); chk_fetch("st.rel", 32'h33, 6'd2);
    step(); chk_fetch("st.w3", 32'h44, 6'd3);
    step(); chk_bubble("st.end", 1'b1);

    // Async reset mid-run, then error on empty run_start
    start_run();
    for (int i = 0; i < 3; i++) step();
    chk_fetch("ar.pre", 32'h33, 6'd2);
    #2 reset = 1'b0;
    #1;
    chk("ar.instr", instr, 32'h0);
    chk("ar.valid", {31'd0, instr_valid}, 32'd0);
    chk("ar.pc", {26'd0, pc}, 32'd0);
    step();
    reset = 1'b1;
    start_run();
    chk("err.set", {31'd0, error}, 32'd1);
    chk("err.valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("err.sticky", {31'd0, error}, 32'd1);
    chk("err.valid2", {31'd0, instr_valid}, 32'd0);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("err.clr", {31'd0, error}, 32'd0);
    chk("err.ready", {31'd0, load_ready}, 32'd1);

    // Full memory load, load_last never asserted
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1; load_data = 32'hA000_0000 + i; load_last = 1'b0;
      step();
      chk("full.done", {31'd0, load_done}, {31'd0, i == 63});
    end
    load_valid = 1'b0;
    chk("full.ready_off", {31'd0, load_ready}, 32'd0);
    step();
    chk("full.done_pulse", {31'd0, load_done}, 32'd0);
    start_run();
    for (int i = 0; i < 64; i++) begin
      step();
      chk_fetch("full.run", 32'hA000_0000 + i, 6'(i));
    end
    step();
    chk_bubble("full.halt", 1'b1);
    chk("full.nowrap_pc", {26'd0, pc}, 32'd63);
    step();
    chk("full.stay_valid", {31'd0, instr_valid}, 32'd0);
    chk("full.stay_halt", {31'd0, halted}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_loader.md
Name: instr_fetch_loader

Overview:
Instruction source for the single-cycle core, which takes its 32-bit instruction word from outside. The block accepts a program from a host over a valid/ready load port into an internal instruction memory. It then runs that program by presenting one instruction per cycle on instr. It honours the core's pcsrc/branch redirect and stall, and reports completion with halted.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words
ADDR_W, 6, PC/address width; must be at least log2(DEPTH)
NOP_WORD, 32'h00000000, word driven on instr when no valid instruction is present

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
load_start  input  1  begin program load (IDLE/HALT only)
load_valid  input  1  load_data valid
load_data  input  32  program word
load_last  input  1  qualifies final word of program
load_ready  output  1  block accepts a load word this cycle
load_done  output  1  one-cycle pulse after final word is written
run_start  input  1  begin execution from address 0 (IDLE/HALT only)
pcsrc  input  1  redirect fetch to branch_target
branch_target  input  ADDR_W  redirect address
stall  input  1  hold current instruction and PC
instr  output  32  instruction to core
instr_valid  output  1  instr holds a real fetched word
pc  output  ADDR_W  address of word currently on instr
halted  output  1  program ran off end of loaded code
error  output  1  sticky: run_start with no program loaded

Behaviour:
- Reset (reset=0, async): state IDLE, fetch_pc=0, wr_ptr=0, count=0, instr=NOP_WORD, instr_valid=0, pc=0, load_ready=0, load_done=0, halted=0, error=0. Memory contents are not cleared, but count=0 forces a reload before any run. Reset mid-load or mid-run aborts immediately to IDLE.
- States: IDLE, LOAD, RUN, HALT.
- IDLE/HALT:
  - load_start -> LOAD; wr_ptr=0; error cleared; halted cleared.
  - Else run_start with count>0 -> RUN; fetch_pc=0; halted cleared.
  - run_start with count=0 -> error=1; stay in current state.
  - load_start and run_start in the same cycle: load_start wins.
- LOAD:
  - load_ready=1 combinationally while in LOAD.
  - Transfer on load_valid&&load_ready: mem[wr_ptr]<=load_data; wr_ptr++.
  - Load ends on a transfer with load_last=1, or on a transfer at wr_ptr=DEPTH-1 (full, load_last ignored). Then count<=wr_ptr+1, load_done=1 for the next cycle only, state -> IDLE.
  - load_valid=0 cycles are ignored. No timeout.
- RUN, synchronous memory read, one word per cycle:
  - stall=1: all registers hold (instr, instr_valid, pc, fetch_pc). pcsrc is ignored while stalled.
  - pcsrc=1, stall=0: fetch_pc<=branch_target; instr<=NOP_WORD; instr_valid<=0 (one-bubble flush).
  - Otherwise, if fetch_pc<count: instr<=mem[fetch_pc]; pc<=fetch_pc; instr_valid<=1; fetch_pc<=fetch_pc+1.
  - Otherwise (fetch_pc>=count, including an out-of-range branch target): instr<=NOP_WORD; instr_valid<=0; halted<=1; state -> HALT.
- Latency: run_start sampled at edge E0. mem[0] appears on instr with instr_valid=1 after edge E1. Steady state: 1 word per non-stalled cycle.
- fetch_pc never wraps: with count=DEPTH, fetch_pc reaching DEPTH needs ADDR_W+1 bits internally, and this forces HALT.
- HALT: instr=NOP_WORD, instr_valid=0, halted=1 until load_start or run_start.

Test Plan:
- Load: 4 words (0x11,0x22,0x33,0x44 with load_last on 0x44), load_valid toggled every other cycle -> exactly 4 writes, load_done single pulse, count=4.
- Run: run_start after load -> instr 0x11,0x22,0x33,0x44 on consecutive cycles with pc 0..3 and instr_valid=1. The next cycle gives instr=NOP_WORD, instr_valid=0, halted=1.
- Branch: pcsrc=1, branch_target=1 while pc=2 -> one bubble (instr_valid=0), then 0x22, 0x33. Branch_target=9 with count=4 -> halted next cycle.
- Stall: stall high 3 cycles while instr=0x22 -> instr/pc frozen; a pcsrc pulse during the stall has no effect; 0x33 follows the release.
- Full memory: stream 64 words with load_last never asserted -> load ends at word 63 with load_done pulse. A run fetches pc 0..63, then halts with no wrap to 0.
- Reset and error: reset=0 mid-RUN at pc=2 -> asynchronously instr=NOP_WORD, instr_valid=0, state IDLE. run_start then sets error=1 with instr_valid staying 0. A following load_start clears error.
